// File: rtl/axi2mem_rd_cmd_gen_if.sv
// AR-channel and per-beat command signals of the read command generator.
// The slave modport is the generator itself; master is the surrounding environment.
interface axi2mem_rd_cmd_gen_if #(
    parameter int ID_WIDTH   = 6,
    parameter int ADDR_WIDTH = 32
);
    logic                  ar_valid;
    logic                  ar_ready;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]            ar_len;
    logic [2:0]            ar_size;
    logic [1:0]            ar_burst;
    logic [ID_WIDTH-1:0]   ar_id;
    logic                  trans_req;
    logic                  trans_gnt;
    logic [ADDR_WIDTH-1:0] trans_add;
    logic [ID_WIDTH-1:0]   trans_id;
    logic                  trans_last;
    logic                  err;

    modport slave (
        input  ar_valid, ar_addr, ar_len, ar_size, ar_burst, ar_id, trans_gnt,
        output ar_ready, trans_req, trans_add, trans_id, trans_last, err
    );

    modport master (
        output ar_valid, ar_addr, ar_len, ar_size, ar_burst, ar_id, trans_gnt,
        input  ar_ready, trans_req, trans_add, trans_id, trans_last, err
    );
endinterface

// File: rtl/axi2mem_rd_cmd_gen.sv
// Expands one AXI AR burst (FIXED/INCR/WRAP, 32-bit data path) into one
// single-beat read command per beat, carrying byte address, ID and last flag.
module axi2mem_rd_cmd_gen #(
    parameter int ID_WIDTH   = 6,
    parameter int ADDR_WIDTH = 32
) (
    input logic                 clk_i,
    input logic                 rst_i,
    axi2mem_rd_cmd_gen_if.slave bus
);
    typedef enum logic {
        IDLE,
        BURST
    } state_e;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } burst_e;

    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    state_e                state;
    logic                  ar_ready_q;
    logic                  req_q;
    logic                  last_q;
    logic [ADDR_WIDTH-1:0] add_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [7:0]            len_q;
    logic [7:0]            beat_cnt;
    logic [1:0]            size_q;
    burst_e                burst_q;

    logic [1:0]            san_size;
    burst_e                san_burst;
    logic                  illegal;
    logic [ADDR_WIDTH-1:0] san_mask;
    logic                  wrap_len_ok;

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] next_add;

    // Illegal AR fields are folded onto the nearest legal burst instead of rejected.
    always_comb begin
        san_size    = (bus.ar_size > 3'd2) ? 2'd2 : bus.ar_size[1:0];
        san_mask    = (ONE << san_size) - ONE;
        san_burst   = burst_e'(bus.ar_burst);
        illegal     = (bus.ar_size > 3'd2);
        wrap_len_ok = (bus.ar_len == 8'd1) || (bus.ar_len == 8'd3) ||
                      (bus.ar_len == 8'd7) || (bus.ar_len == 8'd15);
        case (burst_e'(bus.ar_burst))
            BURST_WRAP: begin
                if (!wrap_len_ok || ((bus.ar_addr & san_mask) != '0)) begin
                    san_burst = BURST_INCR;
                    illegal   = 1'b1;
                end
            end
            BURST_RSVD: begin
                san_burst = BURST_INCR;
                illegal   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Address of the beat after the current one; INCR realigns to the beat size.
    always_comb begin
        step      = ONE << size_q;
        wrap_mask = ((ADDR_WIDTH'(len_q) + ONE) << size_q) - ONE;
        case (burst_q)
            BURST_FIXED: next_add = add_q;
            BURST_WRAP:  next_add = (add_q & ~wrap_mask) | ((add_q + step) & wrap_mask);
            default:     next_add = (add_q & ~(step - ONE)) + step;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            ar_ready_q <= 1'b1;
            req_q      <= 1'b0;
            last_q     <= 1'b0;
            add_q      <= '0;
            id_q       <= '0;
            len_q      <= '0;
            beat_cnt   <= '0;
            size_q     <= '0;
            burst_q    <= BURST_FIXED;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.ar_valid) begin
                        add_q      <= bus.ar_addr;
                        id_q       <= bus.ar_id;
                        len_q      <= bus.ar_len;
                        beat_cnt   <= bus.ar_len;
                        size_q     <= san_size;
                        burst_q    <= san_burst;
                        last_q     <= (bus.ar_len == 8'd0);
                        req_q      <= 1'b1;
                        ar_ready_q <= 1'b0;
                        state      <= BURST;
                    end
                end
                BURST: begin
                    if (bus.trans_gnt) begin
                        if (beat_cnt == 8'd0) begin
                            req_q      <= 1'b0;
                            last_q     <= 1'b0;
                            ar_ready_q <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt - 8'd1;
                            add_q    <= next_add;
                            last_q   <= (beat_cnt == 8'd1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ar_ready   = ar_ready_q;
    assign bus.trans_req  = req_q;
    assign bus.trans_add  = add_q;
    assign bus.trans_id   = id_q;
    assign bus.trans_last = last_q;
    assign bus.err        = ar_ready_q & bus.ar_valid & illegal;
endmodule

// File: tb/tb_axi2mem_rd_cmd_gen.sv
// Directed and randomized bursts against a closed-form per-beat address model,
// covering backpressure, sanitised ARs and asynchronous reset mid-burst.
module tb_axi2mem_rd_cmd_gen;
    logic clk_i = 1'b0;
    logic rst_i;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] exp_q[$];
    logic        exp_err;

    always #5 clk_i = ~clk_i;

    axi2mem_rd_cmd_gen_if #(.ID_WIDTH(6), .ADDR_WIDTH(32)) bus ();

    axi2mem_rd_cmd_gen #(.ID_WIDTH(6), .ADDR_WIDTH(32)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Beat i address computed directly from the start address, not by stepping.
    task automatic buildModel(input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst);
        logic [1:0]  b;
        logic [31:0] step;
        logic [31:0] wb;
        logic [31:0] base;
        logic [31:0] a;
        exp_q.delete();
        b       = burst;
        exp_err = (size > 3'd2);
        step    = 32'd1 << ((size > 3'd2) ? 3'd2 : size);
        if (b == 2'd3) begin
            b       = 2'd1;
            exp_err = 1'b1;
        end
        if (b == 2'd2 && (!(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15) || (addr % step) != 0)) begin
            b       = 2'd1;
            exp_err = 1'b1;
        end
        wb   = (32'(len) + 32'd1) * step;
        base = addr - (addr % wb);
        for (int i = 0; i <= int'(len); i++) begin
            if (i == 0 || b == 2'd0)
                a = addr;
            else if (b == 2'd1)
                a = (addr / step) * step + 32'(i) * step;
            else
                a = base + ((addr - base) + 32'(i) * step) % wb;
            exp_q.push_back(a);
        end
    endtask

    // gnt_mode: 0 always grant, 1 random grant, 2 stall 3 cycles on the 2nd beat.
    // abort_at >= 0 pulses reset just before that beat would be granted.
    task automatic applyStimulus(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                                 input logic [1:0] burst, input logic [5:0] id,
                                 input int gnt_mode, input int abort_at);
        int  head;
        int  n;
        int  stall;
        int  cycles;
        int  budget;
        logic gnt;
        buildModel(addr, len, size, burst);
        n      = exp_q.size();
        budget = n * 8 + 20;
        bus.ar_addr   = addr;
        bus.ar_len    = len;
        bus.ar_size   = size;
        bus.ar_burst  = burst;
        bus.ar_id     = id;
        bus.ar_valid  = 1'b1;
        bus.trans_gnt = 1'($urandom_range(0, 1));
        @(negedge clk_i);
        checkOutput("ar_ready_idle", 32'(bus.ar_ready), 32'd1);
        checkOutput("err_accept", 32'(bus.err), 32'(exp_err));
        @(posedge clk_i);
        #1;
        bus.ar_valid = 1'b0;
        bus.ar_addr  = $urandom;
        bus.ar_len   = 8'($urandom);
        bus.ar_size  = 3'($urandom);
        bus.ar_burst = 2'($urandom);
        bus.ar_id    = 6'($urandom);
        head   = 0;
        stall  = 0;
        cycles = 0;
        while (head < n && cycles < budget) begin
            if (head == abort_at) begin
                bus.trans_gnt = 1'b0;
                #2 rst_i = 1'b1;
                #1;
                checkOutput("rst_req_drop", 32'(bus.trans_req), 32'd0);
                checkOutput("rst_ar_ready", 32'(bus.ar_ready), 32'd1);
                checkOutput("rst_last", 32'(bus.trans_last), 32'd0);
                checkOutput("rst_add", bus.trans_add, 32'd0);
                @(posedge clk_i);
                #1 rst_i = 1'b0;
                return;
            end
            case (gnt_mode)
                0:       gnt = 1'b1;
                1:       gnt = ($urandom_range(0, 3) != 0);
                default: begin
                    gnt = !(head == 1 && stall < 3);
                    if (!gnt) stall++;
                end
            endcase
            bus.trans_gnt = gnt;
            @(negedge clk_i);
            checkOutput("beat_req", 32'(bus.trans_req), 32'd1);
            checkOutput("beat_ar_ready", 32'(bus.ar_ready), 32'd0);
            checkOutput("beat_add", bus.trans_add, exp_q[head]);
            checkOutput("beat_id", 32'(bus.trans_id), 32'(id));
            checkOutput("beat_last", 32'(bus.trans_last), 32'(head == n - 1));
            checkOutput("beat_err", 32'(bus.err), 32'd0);
            if (gnt) head++;
            cycles++;
            @(posedge clk_i);
            #1;
        end
        bus.trans_gnt = 1'b0;
        if (head < n) checkOutput("burst_timeout", 32'(head), 32'(n));
        checkOutput("post_req", 32'(bus.trans_req), 32'd0);
        checkOutput("post_ar_ready", 32'(bus.ar_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] r_addr;
        logic [7:0]  r_len;
        logic [2:0]  r_size;
        rst_i         = 1'b1;
        bus.ar_valid  = 1'b0;
        bus.ar_addr   = '0;
        bus.ar_len    = '0;
        bus.ar_size   = '0;
        bus.ar_burst  = '0;
        bus.ar_id     = '0;
        bus.trans_gnt = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("reset_ar_ready", 32'(bus.ar_ready), 32'd1);
        checkOutput("reset_req", 32'(bus.trans_req), 32'd0);
        checkOutput("reset_last", 32'(bus.trans_last), 32'd0);
        checkOutput("reset_err", 32'(bus.err), 32'd0);
        checkOutput("reset_add", bus.trans_add, 32'd0);
        checkOutput("reset_id", 32'(bus.trans_id), 32'd0);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        applyStimulus(32'h100, 8'd3, 3'd2, 2'd1, 6'd5, 0, -1);
        applyStimulus(32'h108, 8'd3, 3'd2, 2'd2, 6'd9, 0, -1);
        applyStimulus(32'h40, 8'd2, 3'd2, 2'd0, 6'd1, 0, -1);
        applyStimulus(32'h3, 8'd2, 3'd0, 2'd1, 6'd2, 0, -1);
        applyStimulus(32'h200, 8'd3, 3'd2, 2'd1, 6'd7, 2, -1);
        applyStimulus(32'h0, 8'd1, 3'd3, 2'd3, 6'd3, 0, -1);
        applyStimulus(32'h300, 8'd3, 3'd2, 2'd1, 6'd4, 0, 1);
        applyStimulus(32'h400, 8'd1, 3'd2, 2'd1, 6'd11, 0, -1);
        applyStimulus(32'h500, 8'd0, 3'd1, 2'd1, 6'd12, 0, -1);
        applyStimulus(32'hFFFF_FF00, 8'd255, 3'd2, 2'd1, 6'd63, 1, -1);
        applyStimulus(32'h1234, 8'd15, 3'd2, 2'd2, 6'd13, 1, -1);
        applyStimulus(32'h1006, 8'd7, 3'd1, 2'd2, 6'd14, 0, -1);
        applyStimulus(32'h1002, 8'd3, 3'd2, 2'd2, 6'd15, 0, -1);
        applyStimulus(32'h1000, 8'd2, 3'd2, 2'd2, 6'd16, 0, -1);
        applyStimulus(32'h1003, 8'd3, 3'd2, 2'd1, 6'd17, 0, -1);
        applyStimulus(32'h2001, 8'd4, 3'd5, 2'd0, 6'd18, 0, -1);

        for (int k = 0; k < 60; k++) begin
            r_addr = $urandom;
            if ($urandom_range(0, 2) != 0) r_addr = r_addr & ~32'h3F;
            case ($urandom_range(0, 5))
                0:       r_len = 8'd0;
                1:       r_len = 8'd1;
                2:       r_len = 8'd3;
                3:       r_len = 8'd7;
                4:       r_len = 8'd15;
                default: r_len = 8'($urandom_range(0, 20));
            endcase
            r_size = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            applyStimulus(r_addr, r_len, r_size, 2'($urandom_range(0, 3)), 6'($urandom), 1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
